// File: rtl/axis_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_fifo_pkg: FIFO word-layout offsets and pointer full-test helper.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package axis_fifo_pkg;

  // Memory word is {tlast, tkeep, tdata}; tkeep sits directly above tdata.
  function automatic int keep_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int tlast_bit(input int data_width, input int keep_width);
    return data_width + keep_width;
  endfunction

  // Pointers carry one extra wrap bit: MSB differs and low bits equal means a full ring.
  function automatic logic ptr_full(input logic [31:0] a, input logic [31:0] b,
                                    input int addr_width);
    logic [31:0] low_mask;
    low_mask = (32'd1 << addr_width) - 32'd1;
    return (a[addr_width] != b[addr_width]) && (((a ^ b) & low_mask) == 32'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_fifo_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_fifo_ram: simple dual-port RAM, one write port, one registered read. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axis_fifo_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_WIDTH = 73
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data
);

  logic [WORD_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_frame_fifo_stat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_frame_fifo_stat: store-and-forward AXI-Stream frame FIFO that only   |
// | releases complete good frames. Status outputs need AXIS_FRAME_FIFO_STATUS_EN.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axis_frame_fifo_stat #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter bit DROP_WHEN_FULL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  overflow,
  output logic                  bad_frame,
  output logic                  good_frame,
  output logic [ADDR_WIDTH:0]   frame_count
);
  import axis_fifo_pkg::*;

  localparam int PW         = ADDR_WIDTH + 1;
  localparam int KEEP_LSB   = keep_lsb(DATA_WIDTH);
  localparam int TLAST_BIT  = tlast_bit(DATA_WIDTH, KEEP_WIDTH);
  localparam int WORD_WIDTH = TLAST_BIT + 1;

  logic [PW-1:0]         wr_ptr, wr_ptr_cur, rd_ptr;
  logic                  drop_frame;
  logic                  full, empty, full_cur, space_full;
  logic                  accept, drop_now, wr_en, commit, rd_en;
  logic [WORD_WIDTH-1:0] wr_word, rd_word;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = ptr_full(32'(wr_ptr), 32'(rd_ptr), ADDR_WIDTH);
  assign full_cur = ptr_full(32'(wr_ptr_cur), 32'(wr_ptr), ADDR_WIDTH);
  // Speculative writes must never land on words the reader has not consumed yet.
  assign space_full = ptr_full(32'(wr_ptr_cur), 32'(rd_ptr), ADDR_WIDTH);

  assign input_axis_tready = DROP_WHEN_FULL ? 1'b1 : ~full;
  assign accept   = input_axis_tvalid & input_axis_tready;
  assign drop_now = drop_frame | full_cur | space_full | (DROP_WHEN_FULL & full);
  assign wr_en    = accept & ~drop_now;
  assign commit   = wr_en & input_axis_tlast & ~input_axis_tuser;
  assign wr_word  = {input_axis_tlast, input_axis_tkeep, input_axis_tdata};
  assign rd_en    = (output_axis_tready | ~output_axis_tvalid) & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      wr_ptr_cur <= '0;
      drop_frame <= 1'b0;
    end else if (accept) begin
      if (drop_now) begin
        if (input_axis_tlast) begin
          wr_ptr_cur <= wr_ptr;
          drop_frame <= 1'b0;
        end else begin
          drop_frame <= 1'b1;
        end
      end else begin
        wr_ptr_cur <= wr_ptr_cur + PW'(1);
        if (input_axis_tlast) begin
          if (input_axis_tuser) begin
            wr_ptr_cur <= wr_ptr;
          end else begin
            wr_ptr <= wr_ptr_cur + PW'(1);
          end
        end
      end
    end
  end

  // The RAM read register doubles as the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr             <= '0;
      output_axis_tvalid <= 1'b0;
    end else if (rd_en) begin
      rd_ptr             <= rd_ptr + PW'(1);
      output_axis_tvalid <= 1'b1;
    end else if (output_axis_tready) begin
      output_axis_tvalid <= 1'b0;
    end
  end

  axis_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_cur[ADDR_WIDTH-1:0]),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (rd_word)
  );

  assign output_axis_tdata = rd_word[DATA_WIDTH-1:0];
  assign output_axis_tkeep = rd_word[TLAST_BIT-1:KEEP_LSB];
  assign output_axis_tlast = rd_word[TLAST_BIT];

`ifdef AXIS_FRAME_FIFO_STATUS_EN
  logic out_last_done;
  assign out_last_done = output_axis_tvalid & output_axis_tready & output_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow    <= 1'b0;
      bad_frame   <= 1'b0;
      good_frame  <= 1'b0;
      frame_count <= '0;
    end else begin
      overflow   <= accept & drop_now & input_axis_tlast;
      bad_frame  <= wr_en & input_axis_tlast & input_axis_tuser;
      good_frame <= commit;
      case ({commit, out_last_done})
        2'b10:   frame_count <= frame_count + PW'(1);
        2'b01:   frame_count <= frame_count - PW'(1);
        default: frame_count <= frame_count;
      endcase
    end
  end
`else
  assign overflow    = 1'b0;
  assign bad_frame   = 1'b0;
  assign good_frame  = 1'b0;
  assign frame_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_fifo_stat.sv
`default_nettype none
// Self-checking bench for axis_frame_fifo_stat: scoreboard of expected output
// beats plus directed status-pulse and frame-count checks.
module tb_axis_frame_fifo_stat;
  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int DEPTH = 16;
  localparam int WW    = DW + KW + 1;
`ifdef AXIS_FRAME_FIFO_STATUS_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] input_axis_tdata = '0;
  logic [KW-1:0] input_axis_tkeep = '0;
  logic          input_axis_tvalid = 1'b0;
  logic          input_axis_tready;
  logic          input_axis_tlast = 1'b0;
  logic          input_axis_tuser = 1'b0;
  logic [DW-1:0] output_axis_tdata;
  logic [KW-1:0] output_axis_tkeep;
  logic          output_axis_tvalid;
  logic          output_axis_tready = 1'b1;
  logic          output_axis_tlast;
  logic          overflow, bad_frame, good_frame;
  logic [AW:0]   frame_count;

  always #5 clk = ~clk;

  axis_frame_fifo_stat #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .KEEP_WIDTH     (KW),
    .DROP_WHEN_FULL (1'b1)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (input_axis_tdata),
    .input_axis_tkeep   (input_axis_tkeep),
    .input_axis_tvalid  (input_axis_tvalid),
    .input_axis_tready  (input_axis_tready),
    .input_axis_tlast   (input_axis_tlast),
    .input_axis_tuser   (input_axis_tuser),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tkeep  (output_axis_tkeep),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .output_axis_tlast  (output_axis_tlast),
    .overflow           (overflow),
    .bad_frame          (bad_frame),
    .good_frame         (good_frame),
    .frame_count        (frame_count)
  );

  int checks = 0;
  int failures = 0;
  int n_ovf = 0, n_bad = 0, n_good = 0;
  logic [WW-1:0] sb[$];
  logic [WW-1:0] exp_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Monitor: counts status pulses and checks every output handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (overflow)   n_ovf++;
      if (bad_frame)  n_bad++;
      if (good_frame) n_good++;
      if (output_axis_tvalid && output_axis_tready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got=%h exp=none",
                   {output_axis_tlast, output_axis_tkeep, output_axis_tdata});
        end else begin
          exp_w = sb.pop_front();
          if ({output_axis_tlast, output_axis_tkeep, output_axis_tdata} !== exp_w) begin
            failures++;
            $display("FAIL out_beat got=%h exp=%h",
                     {output_axis_tlast, output_axis_tkeep, output_axis_tdata}, exp_w);
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input logic u);
    int t;
    t = 0;
    input_axis_tdata  = d;
    input_axis_tkeep  = k;
    input_axis_tlast  = l;
    input_axis_tuser  = u;
    input_axis_tvalid = 1'b1;
    while (!input_axis_tready && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout got=0 exp=1");
    end
    @(posedge clk); #1;
    input_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input int tag, input bit bad, input bit push);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    for (int i = 0; i < len; i++) begin
      l = (i == len - 1);
      d = {tag[31:0], i[31:0]};
      k = l ? 8'(8'hFF >> (tag % 8)) : 8'hFF;
      if (push && !bad) sb.push_back({l, k, d});
      send_beat(d, k, l, bad && l);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got=%0d exp=0 beats pending", name, sb.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rand_good, n_rand_bad, len, t;
    bit bad, rand_done;
    n_rand_good = 0;
    n_rand_bad  = 0;
    rand_done   = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_tvalid", 64'(output_axis_tvalid), 0);
    check("reset_frame_count", 64'(frame_count), 0);
    check("reset_tready", 64'(input_axis_tready), 1);

    // Basic 3-beat frame, held at the output so frame_count can be observed.
    output_axis_tready = 1'b0;
    sb.push_back({1'b0, 8'hFF, 64'h11});
    sb.push_back({1'b0, 8'hFF, 64'h22});
    sb.push_back({1'b1, 8'hFF, 64'h33});
    send_beat(64'h11, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h22, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h33, 8'hFF, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("basic_good_pulses", 64'(n_good), 64'(STAT));
    check("basic_frame_count_1", 64'(frame_count), 64'(STAT));
    check("basic_tvalid", 64'(output_axis_tvalid), 1);
    output_axis_tready = 1'b1;
    drain("basic");
    check("basic_frame_count_0", 64'(frame_count), 0);

    // Bad frame is discarded.
    send_frame(2, 'hB0, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("bad_pulses", 64'(n_bad), 64'(STAT));
    check("bad_no_output", 64'(output_axis_tvalid), 0);
    check("bad_good_unchanged", 64'(n_good), 64'(STAT));

    // Oversize frame then a short good frame.
    send_frame(20, 'hC0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("oversize_ovf", 64'(n_ovf), 64'(STAT));
    check("oversize_no_output", 64'(output_axis_tvalid), 0);
    send_frame(2, 'hC1, 1'b0, 1'b1);
    drain("after_oversize");
    check("after_oversize_good", 64'(n_good), 64'(2 * STAT));

    // Fill with 8+6 beats under backpressure, third frame cannot fit.
    output_axis_tready = 1'b0;
    send_frame(8, 'hD0, 1'b0, 1'b1);
    send_frame(6, 'hD1, 1'b0, 1'b1);
    send_frame(4, 'hD2, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("full_ovf", 64'(n_ovf), 64'(2 * STAT));
    check("full_frame_count", 64'(frame_count), 64'(2 * STAT));
    check("full_good", 64'(n_good), 64'(4 * STAT));
    output_axis_tready = 1'b1;
    drain("full");
    check("full_frame_count_0", 64'(frame_count), 0);

    // Random backpressure over 100 frames; sender only issues frames that fit.
    fork
      begin
        for (int f = 0; f < 100; f++) begin
          len = $urandom_range(1, 7);
          bad = ($urandom_range(0, 4) == 0);
          t = 0;
          while (sb.size() + len > DEPTH && t < 5000) begin
            @(posedge clk); #1;
            t++;
          end
          if (t >= 5000) begin
            checks++;
            failures++;
            $display("FAIL rand_room got=%0d exp<=%0d", sb.size() + len, DEPTH);
          end
          if (bad) n_rand_bad++; else n_rand_good++;
          send_frame(len, 'h100 + f, bad, 1'b1);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          output_axis_tready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    output_axis_tready = 1'b1;
    drain("random");
    check("rand_good", 64'(n_good), 64'(STAT * (4 + n_rand_good)));
    check("rand_bad", 64'(n_bad), 64'(STAT * (1 + n_rand_bad)));
    check("rand_ovf", 64'(n_ovf), 64'(2 * STAT));
    check("rand_frame_count_0", 64'(frame_count), 0);

    // Reset in the middle of a frame with a committed frame pending at the output.
    output_axis_tready = 1'b0;
    send_frame(3, 'hE0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_tvalid", 64'(output_axis_tvalid), 1);
    send_beat(64'hDEAD, 8'hFF, 1'b0, 1'b0);
    send_beat(64'hBEEF, 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_tvalid", 64'(output_axis_tvalid), 0);
    check("midreset_frame_count", 64'(frame_count), 0);
    sb.delete();
    rst = 1'b0;
    output_axis_tready = 1'b1;
    send_frame(3, 'hE1, 1'b0, 1'b1);
    drain("post_reset");
    check("post_reset_frame_count", 64'(frame_count), 0);
    check("post_reset_good", 64'(n_good), 64'(STAT * (6 + n_rand_good)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
